// File: rtl/booth_controller.sv
// Control FSM for a radix-2 Booth multiplier (8-bit operands).
// Sequences operand loading, add/subtract into the accumulator and the
// arithmetic right shift of A/Q/Q-1, using an external iteration counter.
// All strobes are Moore outputs decoded from the state register alone.
module booth_controller #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q0,
  input  logic             qm1,
  input  logic [CNT_W-1:0] count,
  output logic             ldA,
  output logic             clrA,
  output logic             sftA,
  output logic             ldQ,
  output logic             clrQ,
  output logic             sftQ,
  output logic             ldM,
  output logic             clrff,
  output logic             addsub,
  output logic             ldcnt,
  output logic             decr,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LDM   = 3'd1,
    LDQ   = 3'd2,
    EVAL  = 3'd3,
    ADD   = 3'd4,
    SUB   = 3'd5,
    SHIFT = 3'd6,
    DONE  = 3'd7
  } state_t;

  state_t state_q, state_d;

  // State register with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; in EVAL the count check outranks the Booth pair
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:  state_d = start ? LDM : IDLE;
      LDM:   state_d = LDQ;
      LDQ:   state_d = EVAL;
      EVAL: begin
        if (count == '0)             state_d = DONE;
        else if ({q0, qm1} == 2'b01) state_d = ADD;
        else if ({q0, qm1} == 2'b10) state_d = SUB;
        else                         state_d = SHIFT;
      end
      ADD:   state_d = SHIFT;
      SUB:   state_d = SHIFT;
      SHIFT: state_d = EVAL;
      DONE:  state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode; every strobe defaults low
  always_comb begin
    ldA    = 1'b0;
    clrA   = 1'b0;
    sftA   = 1'b0;
    ldQ    = 1'b0;
    clrQ   = 1'b0;
    sftQ   = 1'b0;
    ldM    = 1'b0;
    clrff  = 1'b0;
    addsub = 1'b0;
    ldcnt  = 1'b0;
    decr   = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      LDM: begin
        ldM   = 1'b1;
        clrA  = 1'b1;
        clrff = 1'b1;
        ldcnt = 1'b1;
        busy  = 1'b1;
      end
      LDQ: begin
        ldQ  = 1'b1;
        busy = 1'b1;
      end
      EVAL: busy = 1'b1;
      ADD: begin
        ldA    = 1'b1;
        addsub = 1'b1;
        busy   = 1'b1;
      end
      SUB: begin
        ldA  = 1'b1;
        busy = 1'b1;
      end
      SHIFT: begin
        sftA = 1'b1;
        sftQ = 1'b1;
        decr = 1'b1;
        busy = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/booth_controller.md
# booth_controller

Control FSM for the radix-2 Booth multiplier; sits directly upstream of the iteration counter and drives its `ldcnt`/`decr` inputs, consuming its 4-bit `count` to terminate. It sequences operand loading, add/subtract of the multiplicand into the accumulator, and the arithmetic right shift of the A/Q/Q-1 chain for an 8-bit multiply. It produces Moore-style control strobes for the datapath and a start/done handshake toward the host.

## Interface
- `CNT_W`, default 4: width of the `count` input. It must hold the counter load value 8.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a multiply. Sampled only in IDLE.
- `q0` in 1: LSB of the Q register.
- `qm1` in 1: Q-1 flip-flop.
- `count` in CNT_W: iteration count from the counter.
- `ldA`, `clrA`, `sftA` out 1: accumulator load, clear and arithmetic right shift.
- `ldQ`, `clrQ`, `sftQ` out 1: multiplier register load, clear and shift.
- `ldM` out 1: multiplicand register load.
- `clrff` out 1: clear the Q-1 flip-flop.
- `addsub` out 1: ALU select. 1 = A+M, 0 = A−M.
- `ldcnt` out 1: counter load strobe. The counter loads 8.
- `decr` out 1: counter decrement strobe.
- `busy` out 1: high in every state except IDLE and DONE.
- `done` out 1: high only in DONE.

## Operation
- The state register is binary encoded. All outputs decode from state only; there is no input-to-output combinational path.
- Any output not listed for a state is 0 in that state.
- States and their outputs:
  - IDLE: outputs all 0. Moves to LDM when `start`=1.
  - LDM: `ldM`=1, `clrA`=1, `clrff`=1, `ldcnt`=1. Moves to LDQ. The host presents the multiplicand on the shared data bus.
  - LDQ: `ldQ`=1. Moves to EVAL. The host presents the multiplier.
  - EVAL: outputs 0. Transitions are checked in this priority order:
    1. `count`==0 → DONE.
    2. {`q0`,`qm1`}=01 → ADD.
    3. {`q0`,`qm1`}=10 → SUB.
    4. {`q0`,`qm1`}=00 or 11 → SHIFT.
  - ADD: `ldA`=1, `addsub`=1. Moves to SHIFT.
  - SUB: `ldA`=1, `addsub`=0. Moves to SHIFT.
  - SHIFT: `sftA`=1, `sftQ`=1, `decr`=1. Moves to EVAL.
  - DONE: `done`=1. Moves to IDLE when `start`=0; stays in DONE while `start`=1, so there is no retrigger.
- The zero check uses all CNT_W bits of `count`.
- The count check has priority over the {`q0`,`qm1`} pair in EVAL. No ADD, SUB or SHIFT is issued once `count`==0, so `decr` never underflows the counter.
- `start` asserted in any state other than IDLE is ignored.
- Unused state encodings go to IDLE on the next edge.
- `clrQ` is held 0 in every state (reserved).

## Timing
- Reset: on a rising edge with `rst`=1, state becomes IDLE and every output is 0, regardless of state or `start`.
- Reset mid-operation aborts the multiply. Datapath contents are don't-care afterwards.
- Reference edge: `start` is sampled high in IDLE at edge E0.
- E0 → LDM, E1 → LDQ, E2 → first EVAL.
- The counter reads 8 from the cycle after LDM.
- Each iteration takes 2 cycles (EVAL, SHIFT), or 3 cycles (EVAL, ADD/SUB, SHIFT).
- `count` reaches 0 after the 8th SHIFT; the next EVAL moves to DONE.
- `done` rises after edge E0+19 when no add/subtract occurs. Each ADD or SUB adds one cycle, so the maximum is E0+27.
- `busy` rises after E0 and falls when DONE is entered.
- `q0` and `qm1` are sampled in EVAL after the preceding SHIFT has committed.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `start`=1 → state IDLE; all outputs, `busy` and `done` are 0; no `ldcnt`.
- All-zero multiplier: the bench counter model starts at 8 and {`q0`,`qm1`}=00 throughout → 8 `decr`/`sftA` pulses, 0 `ldA` pulses, `done` after E0+19.
- Multiplier 0x55 with the bench shifting Q → alternating SUB/ADD, 8 `ldA` pulses (`addsub` sequence 0,1,0,1,…), `done` after E0+27.
- Reset asserted during the 4th SHIFT → IDLE on the next edge with all outputs 0. A fresh `start` then completes normally with correct latency.
- Hold `start`=1 through DONE → `done` stays high with no new LDM. Drop `start` → IDLE next edge. Pulse `start` while `busy` → no effect.
- Integrated with the counter and datapath, M=8'd7, Q=8'hFD (−3) → product {A,Q}=16'hFFEB (−21) when `done` is high.
